// File: rtl/vga_pattern_pkg.sv
// Shared encodings, colours and helpers for the VGA test-pattern generator.
// Colours are packed {red[2:0], grn[2:0], blu[2:0]}.
package vga_pattern_pkg;

  localparam logic [1:0] MODE_BARS     = 2'd0;
  localparam logic [1:0] MODE_CHECKER  = 2'd1;
  localparam logic [1:0] MODE_GRADIENT = 2'd2;
  localparam logic [1:0] MODE_BOX      = 2'd3;

  localparam int BAR_WIDTH = 80;

  localparam logic [8:0] COL_WHITE  = 9'b111_111_111;
  localparam logic [8:0] COL_BLACK  = 9'b000_000_000;
  localparam logic [8:0] COL_BOX_BG = 9'b000_000_010;

  // Comparator chain instead of a divide by BAR_WIDTH
  function automatic logic [2:0] bar_index(input logic [9:0] h);
    logic [2:0] idx;
    idx = 3'd7;
    for (int k = 7; k >= 1; k--) begin
      if (h < 10'(BAR_WIDTH * k)) idx = 3'(k - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing box: position and direction, stepped once per tick.
// Position saturates at 0 and LIMIT, reversing direction there.
module vga_bounce_axis #(
  parameter logic [9:0] LIMIT = 10'd608,
  parameter logic [9:0] SPEED = 10'd2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  output logic [9:0] o_pos
);

  logic [9:0]  r_pos;
  logic        r_dir_pos;
  logic [10:0] w_fwd;

  assign w_fwd = {1'b0, r_pos} + {1'b0, SPEED};
  assign o_pos = r_pos;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos     <= '0;
      r_dir_pos <= 1'b1;
    end else if (i_tick) begin
      if (r_dir_pos) begin
        if (w_fwd >= {1'b0, LIMIT}) begin
          r_pos     <= LIMIT;
          r_dir_pos <= 1'b0;
        end else begin
          r_pos <= w_fwd[9:0];
        end
      end else begin
        if (r_pos <= SPEED) begin
          r_pos     <= '0;
          r_dir_pos <= 1'b1;
        end else begin
          r_pos <= r_pos - SPEED;
        end
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage VGA test-pattern generator: stage 1 registers predicates,
// stage 2 picks the colour for the active mode and blanks invisible pixels.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int BOX_SIZE  = 32,
  parameter int BOX_SPEED = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_vblank,
  input  logic       i_visible,
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  input  logic       i_next_mode,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic [2:0] o_red,
  output logic [2:0] o_grn,
  output logic [2:0] o_blu,
  output logic [1:0] o_mode,
  output logic [7:0] o_frame
);

  logic       r_vblank_prev;
  logic       r_pending;
  logic [1:0] r_mode;
  logic [7:0] r_frame;
  logic       w_tick;
  logic       w_pend;
  logic [9:0] w_box_x;
  logic [9:0] w_box_y;
  logic       w_in_box;

  logic       r_s1_hsync, r_s1_vsync, r_s1_vis;
  logic [2:0] r_s1_bar, r_s1_hg, r_s1_vg;
  logic       r_s1_chk, r_s1_box;

  logic       r_hsync, r_vsync;
  logic [8:0] r_rgb;
  logic [8:0] w_col;
  logic [2:0] w_c;

  assign w_tick = i_vblank & ~r_vblank_prev;
  assign w_pend = r_pending | i_next_mode;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vblank_prev <= 1'b0;
      r_pending     <= 1'b0;
      r_mode        <= MODE_BARS;
      r_frame       <= '0;
    end else begin
      r_vblank_prev <= i_vblank;
      r_pending     <= w_pend;
      if (w_tick) begin
        r_frame <= r_frame + 8'd1;
        if (w_pend) begin
          r_mode    <= r_mode + 2'd1;
          r_pending <= 1'b0;
        end
      end
    end
  end

  vga_bounce_axis #(
    .LIMIT (10'(H_VISIBLE - BOX_SIZE)),
    .SPEED (10'(BOX_SPEED))
  ) u_box_x (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tick  (w_tick),
    .o_pos   (w_box_x)
  );

  vga_bounce_axis #(
    .LIMIT (10'(V_VISIBLE - BOX_SIZE)),
    .SPEED (10'(BOX_SPEED))
  ) u_box_y (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tick  (w_tick),
    .o_pos   (w_box_y)
  );

  assign w_in_box =
    ({1'b0, i_hpos} >= {1'b0, w_box_x}) &&
    ({1'b0, i_hpos} <  {1'b0, w_box_x} + 11'(BOX_SIZE)) &&
    ({1'b0, i_vpos} >= {1'b0, w_box_y}) &&
    ({1'b0, i_vpos} <  {1'b0, w_box_y} + 11'(BOX_SIZE));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_hsync <= 1'b0;
      r_s1_vsync <= 1'b0;
      r_s1_vis   <= 1'b0;
      r_s1_bar   <= '0;
      r_s1_chk   <= 1'b0;
      r_s1_hg    <= '0;
      r_s1_vg    <= '0;
      r_s1_box   <= 1'b0;
    end else begin
      r_s1_hsync <= i_hsync;
      r_s1_vsync <= i_vsync;
      r_s1_vis   <= i_visible;
      r_s1_bar   <= bar_index(i_hpos);
      // Checker scrolls horizontally by one pixel per frame
      r_s1_chk   <= (((i_hpos + {2'b0, r_frame}) & 10'h020) != 10'd0)
                    ^ i_vpos[5];
      r_s1_hg    <= i_hpos[8:6];
      r_s1_vg    <= i_vpos[8:6];
      r_s1_box   <= w_in_box;
    end
  end

  assign w_c = 3'd7 - r_s1_bar;

  always_comb begin
    w_col = COL_BLACK;
    unique case (r_mode)
      MODE_BARS:     w_col = {{3{w_c[2]}}, {3{w_c[1]}}, {3{w_c[0]}}};
      MODE_CHECKER:  w_col = r_s1_chk ? COL_WHITE : COL_BLACK;
      MODE_GRADIENT: w_col = {r_s1_hg, r_s1_vg, r_frame[7:5]};
      MODE_BOX:      w_col = r_s1_box ? COL_WHITE : COL_BOX_BG;
      default:       w_col = COL_BLACK;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_hsync <= r_s1_hsync;
      r_vsync <= r_s1_vsync;
      r_rgb   <= r_s1_vis ? w_col : COL_BLACK;
    end
  end

  assign o_hsync = r_hsync;
  assign o_vsync = r_vsync;
  assign o_red   = r_rgb[8:6];
  assign o_grn   = r_rgb[5:3];
  assign o_blu   = r_rgb[2:0];
  assign o_mode  = r_mode;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: one task per feature,
// expected values hand-computed from the pattern definitions.
module tb_vga_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic       hsync, vsync, vblank, visible, next_mode;
  logic [9:0] hpos, vpos;
  logic       o_hsync, o_vsync;
  logic [2:0] o_red, o_grn, o_blu;
  logic [1:0] o_mode;
  logic [7:0] o_frame;

  int n_tests;
  int n_fail;

  vga_pattern_gen dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_hsync     (hsync),
    .i_vsync     (vsync),
    .i_vblank    (vblank),
    .i_visible   (visible),
    .i_hpos      (hpos),
    .i_vpos      (vpos),
    .i_next_mode (next_mode),
    .o_hsync     (o_hsync),
    .o_vsync     (o_vsync),
    .o_red       (o_red),
    .o_grn       (o_grn),
    .o_blu       (o_blu),
    .o_mode      (o_mode),
    .o_frame     (o_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    hsync     = 1'b0;
    vsync     = 1'b0;
    vblank    = 1'b0;
    visible   = 1'b0;
    next_mode = 1'b0;
    hpos      = '0;
    vpos      = '0;
    #23;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic tick_frame(input logic nm);
    vblank    = 1'b1;
    next_mode = nm;
    step();
    vblank    = 1'b0;
    next_mode = 1'b0;
    step();
  endtask

  task automatic pixel(input int h, input int v, output logic [8:0] rgb);
    hpos    = 10'(h);
    vpos    = 10'(v);
    visible = 1'b1;
    step();
    step();
    rgb = {o_red, o_grn, o_blu};
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({o_hsync, o_vsync, o_red, o_grn, o_blu, o_mode, o_frame} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0",
               {o_hsync, o_vsync, o_red, o_grn, o_blu, o_mode, o_frame});
    end
  endtask

  task automatic test_bars();
    logic [2:0] c;
    logic [8:0] exp_rgb;
    int j;
    do_reset();
    vpos = '0;
    for (int i = 0; i <= 640; i++) begin
      if (i < 640) begin
        hpos    = 10'(i);
        hsync   = ((i % 16) < 4);
        vsync   = ((i % 32) == 5);
        visible = 1'b1;
      end else begin
        visible = 1'b0;
        hsync   = 1'b0;
        vsync   = 1'b0;
      end
      step();
      if (i >= 1) begin
        j = i - 1;
        c = 3'(7 - (j / 80));
        exp_rgb = {{3{c[2]}}, {3{c[1]}}, {3{c[0]}}};
        n_tests++;
        if ({o_red, o_grn, o_blu} !== exp_rgb ||
            o_hsync !== ((j % 16) < 4) || o_vsync !== ((j % 32) == 5)) begin
          n_fail++;
          $display("FAIL bars h=%0d got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                   j, {o_red, o_grn, o_blu}, o_hsync, o_vsync, exp_rgb,
                   ((j % 16) < 4), ((j % 32) == 5));
        end
      end
    end
  endtask

  task automatic test_visible_gate();
    logic [8:0] rgb;
    do_reset();
    tick_frame(1'b1);
    tick_frame(1'b1);
    n_tests++;
    if (o_mode !== 2'd2 || o_frame !== 8'd2) begin
      n_fail++;
      $display("FAIL gate_mode got mode=%0d frame=%0d want 2 2", o_mode, o_frame);
    end
    hpos    = 10'd320;
    vpos    = 10'd100;
    visible = 1'b0;
    hsync   = 1'b1;
    vsync   = 1'b0;
    step();
    step();
    n_tests++;
    if ({o_red, o_grn, o_blu} !== 9'd0 || o_hsync !== 1'b1 || o_vsync !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_blank got rgb=%h hs=%b vs=%b want 000 1 0",
               {o_red, o_grn, o_blu}, o_hsync, o_vsync);
    end
    hsync = 1'b0;
    pixel(320, 100, rgb);
    n_tests++;
    if (rgb !== {3'd5, 3'd1, 3'd0}) begin
      n_fail++;
      $display("FAIL gradient got %h want %h", rgb, {3'd5, 3'd1, 3'd0});
    end
  endtask

  task automatic test_checker();
    logic [8:0] rgb;
    int ph[4]  = '{31, 30, 30, 31};
    int pv[4]  = '{0, 0, 32, 32};
    logic [8:0] pe[4] = '{9'h1FF, 9'h000, 9'h1FF, 9'h000};
    do_reset();
    tick_frame(1'b1);
    for (int k = 0; k < 4; k++) begin
      pixel(ph[k], pv[k], rgb);
      n_tests++;
      if (rgb !== pe[k]) begin
        n_fail++;
        $display("FAIL checker (%0d,%0d) got %h want %h", ph[k], pv[k], rgb, pe[k]);
      end
    end
  endtask

  task automatic test_mode_change();
    do_reset();
    next_mode = 1'b1;
    step();
    next_mode = 1'b0;
    step();
    step();
    next_mode = 1'b1;
    step();
    next_mode = 1'b0;
    step();
    n_tests++;
    if (o_mode !== 2'd0) begin
      n_fail++;
      $display("FAIL mode_midframe got %0d want 0", o_mode);
    end
    tick_frame(1'b0);
    n_tests++;
    if (o_mode !== 2'd1) begin
      n_fail++;
      $display("FAIL mode_one_step got %0d want 1", o_mode);
    end
    tick_frame(1'b0);
    n_tests++;
    if (o_mode !== 2'd1) begin
      n_fail++;
      $display("FAIL mode_pending_cleared got %0d want 1", o_mode);
    end
    tick_frame(1'b1);
    n_tests++;
    if (o_mode !== 2'd2 || o_frame !== 8'd3) begin
      n_fail++;
      $display("FAIL mode_same_cycle got mode=%0d frame=%0d want 2 3", o_mode, o_frame);
    end
    tick_frame(1'b1);
    tick_frame(1'b1);
    n_tests++;
    if (o_mode !== 2'd0) begin
      n_fail++;
      $display("FAIL mode_wrap got %0d want 0", o_mode);
    end
  endtask

  task automatic test_box_motion();
    do_reset();
    repeat (224) tick_frame(1'b0);
    n_tests++;
    if (dut.w_box_x !== 10'd448 || dut.w_box_y !== 10'd448) begin
      n_fail++;
      $display("FAIL box_224 got x=%0d y=%0d want 448 448", dut.w_box_x, dut.w_box_y);
    end
    tick_frame(1'b0);
    n_tests++;
    if (dut.w_box_y !== 10'd446 || dut.w_box_x !== 10'd450) begin
      n_fail++;
      $display("FAIL box_225 got x=%0d y=%0d want 450 446", dut.w_box_x, dut.w_box_y);
    end
    repeat (79) tick_frame(1'b0);
    n_tests++;
    if (dut.w_box_x !== 10'd608 || dut.w_box_y !== 10'd288) begin
      n_fail++;
      $display("FAIL box_304 got x=%0d y=%0d want 608 288", dut.w_box_x, dut.w_box_y);
    end
    tick_frame(1'b0);
    n_tests++;
    if (dut.w_box_x !== 10'd606 || o_frame !== 8'd49) begin
      n_fail++;
      $display("FAIL box_305 got x=%0d frame=%0d want 606 49", dut.w_box_x, o_frame);
    end
  endtask

  task automatic test_box_pixels();
    logic [8:0] rgb;
    int ph[5]  = '{20, 52, 19, 51, 20};
    int pv[5]  = '{20, 20, 51, 51, 52};
    logic [8:0] pe[5] = '{9'h1FF, 9'h002, 9'h002, 9'h1FF, 9'h002};
    do_reset();
    repeat (3) tick_frame(1'b1);
    repeat (7) tick_frame(1'b0);
    n_tests++;
    if (o_mode !== 2'd3 || o_frame !== 8'd10) begin
      n_fail++;
      $display("FAIL box_setup got mode=%0d frame=%0d want 3 10", o_mode, o_frame);
    end
    for (int k = 0; k < 5; k++) begin
      pixel(ph[k], pv[k], rgb);
      n_tests++;
      if (rgb !== pe[k]) begin
        n_fail++;
        $display("FAIL box_pixel (%0d,%0d) got %h want %h", ph[k], pv[k], rgb, pe[k]);
      end
    end
  endtask

  task automatic test_reset_midline();
    logic [8:0] rgb;
    do_reset();
    repeat (3) tick_frame(1'b1);
    repeat (34) tick_frame(1'b0);
    hsync = 1'b1;
    vsync = 1'b1;
    pixel(80, 80, rgb);
    n_tests++;
    if (rgb !== 9'h1FF || o_hsync !== 1'b1 || o_frame !== 8'd37 || o_mode !== 2'd3) begin
      n_fail++;
      $display("FAIL pre_reset got rgb=%h hs=%b frame=%0d mode=%0d want 1ff 1 37 3",
               rgb, o_hsync, o_frame, o_mode);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_hsync, o_vsync, o_red, o_grn, o_blu, o_mode, o_frame} !== 21'd0) begin
      n_fail++;
      $display("FAIL async_reset got %h want 0",
               {o_hsync, o_vsync, o_red, o_grn, o_blu, o_mode, o_frame});
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    n_tests++;
    if (o_mode !== 2'd0 || o_frame !== 8'd0 ||
        dut.w_box_x !== 10'd0 || dut.w_box_y !== 10'd0) begin
      n_fail++;
      $display("FAIL post_reset got mode=%0d frame=%0d x=%0d y=%0d want 0 0 0 0",
               o_mode, o_frame, dut.w_box_x, dut.w_box_y);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_bars();
    test_visible_gate();
    test_checker();
    test_mode_change();
    test_box_motion();
    test_box_pixels();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
